// File: rtl/muldiv_unit_if.sv
// Handshake, operand and HI/LO bus between the multicycle controller and muldiv_unit.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) ();
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic             LoadHi;
  logic             LoadLo;
  logic [WIDTH-1:0] WrData;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic [CNT_W-1:0] Count;

  modport master (
    output Start, Op, OpA, OpB, LoadHi, LoadLo, WrData,
    input  Busy, Done, DivZero, Hi, Lo, Count
  );

  modport slave (
    input  Start, Op, OpA, OpB, LoadHi, LoadLo, WrData,
    output Busy, Done, DivZero, Hi, Lo, Count
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide with architectural HI/LO registers.
// Optional macro MULDIV_EARLY_OUT_EN: multiply leaves CALC once the remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic        Clock,
  input  logic        Reset,
  muldiv_unit_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             divzero_q, divzero_d;

  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [CNT_W-1:0] cnt_inc;
  logic [WIDTH:0]   mul_sum;
  logic [PW-1:0]    mul_next;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [PW-1:0]    div_next;
  logic [PW-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
`ifdef MULDIV_EARLY_OUT_EN
  logic             mul_rest_zero;
  logic [PW-1:0]    mul_aligned;
`endif

  // Per-iteration datapath; acc holds {hi, lo} of product or {remainder, dividend/quotient}
  always_comb begin
    signed_op = ~bus.Op[0];
    a_neg     = signed_op & bus.OpA[WIDTH-1];
    b_neg     = signed_op & bus.OpB[WIDTH-1];
    a_mag     = a_neg ? -bus.OpA : bus.OpA;
    b_mag     = b_neg ? -bus.OpB : bus.OpB;
    cnt_inc   = count_q + CNT_W'(1);

    mul_sum   = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    div_shift = {acc_q[PW-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_diff  = div_shift - {1'b0, b_q};
    div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], div_ge};

    prod_fix  = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo_fix   = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = sign_a_q ? -acc_q[PW-1:WIDTH] : acc_q[PW-1:WIDTH];
`ifdef MULDIV_EARLY_OUT_EN
    // Shifting out the already-consumed product bits leaves only unseen multiplier bits
    mul_rest_zero = (WIDTH'(mul_next[WIDTH-1:0] << cnt_inc) == '0);
    mul_aligned   = PW'(mul_next >> (WIDTH - 32'(cnt_inc)));
`endif
  end

  // Next-state and register updates
  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    b_d       = b_q;
    acc_d     = acc_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    divzero_d = divzero_q;

    case (state_q)
      IDLE: begin
        if (bus.LoadHi) hi_d = bus.WrData;
        if (bus.LoadLo) lo_d = bus.WrData;
        if (bus.Start) begin
          is_div_d  = bus.Op[1];
          sign_a_d  = a_neg;
          sign_b_d  = b_neg;
          b_d       = bus.Op[1] ? b_mag : a_mag;
          acc_d     = {WIDTH'(0), (bus.Op[1] ? a_mag : b_mag)};
          count_d   = '0;
          divzero_d = 1'b0;
          if (bus.Op[1] && (bus.OpB == '0)) begin
            hi_d      = bus.OpA;
            lo_d      = '1;
            divzero_d = 1'b1;
            state_d   = DONE;
          end else begin
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        count_d = cnt_inc;
        if (is_div_q) begin
          acc_d = div_next;
          if (cnt_inc == CNT_W'(WIDTH)) state_d = FIX;
        end else begin
`ifdef MULDIV_EARLY_OUT_EN
          acc_d = mul_next;
          if (mul_rest_zero) begin
            acc_d   = mul_aligned;
            state_d = FIX;
          end
`else
          acc_d = mul_next;
          if (cnt_inc == CNT_W'(WIDTH)) state_d = FIX;
`endif
        end
      end
      FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[PW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = DONE;
      end
      DONE: begin
        if (bus.LoadHi) hi_d = bus.WrData;
        if (bus.LoadLo) lo_d = bus.WrData;
        divzero_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      is_div_q  <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      b_q       <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.DivZero = divzero_q;
  assign bus.Hi      = hi_q;
  assign bus.Lo      = lo_q;
  assign bus.Count   = count_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes reference results, monitor checks them at Done.
module tb_muldiv_unit;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = $clog2(W) + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          cnt;
    int          issue;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  exp_t sb_q[$];

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  muldiv_unit_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  muldiv_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference results from plain 64-bit arithmetic; latency counted in edges from issue
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sb, q, r;
    logic [31:0] mb;
    e.dz = 1'b0; e.lat = W + 2; e.cnt = W; e.issue = 0;
    e.hi = '0; e.lo = '0;
    if (op[1] == 1'b0) begin
      if (op[0] == 1'b0) begin
        sa = $signed(a); sb = $signed(b);
        p  = sa * sb;
        mb = b[31] ? -b : b;
      end else begin
        p  = {32'd0, a} * {32'd0, b};
        mb = b;
      end
      e.hi = p[63:32];
      e.lo = p[31:0];
`ifdef MULDIV_EARLY_OUT_EN
      e.cnt = 1;
      for (int i = 0; i < 32; i++) if (mb[i]) e.cnt = i + 1;
      e.lat = e.cnt + 2;
`else
      mb = '0;
`endif
    end else if (b == 32'd0) begin
      e.hi = a; e.lo = '1; e.dz = 1'b1; e.lat = 1; e.cnt = 0;
    end else if (op[0] == 1'b0) begin
      sa = $signed(a); sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      e.lo = q[31:0];
      e.hi = r[31:0];
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  // Monitor: compare every Done pulse against the oldest outstanding expectation
  always @(negedge Clock) begin
    exp_t e;
    if (!Reset) begin
      busy_cnt = 0;
    end else if (bus.Done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("hi", bus.Hi, e.hi);
        chk("lo", bus.Lo, e.lo);
        chk("divzero", bus.DivZero, e.dz);
        chk("count", bus.Count, e.cnt);
        chk("latency", cyc - e.issue, e.lat);
        chk("busy_cycles", busy_cnt, e.lat - 1);
      end
      busy_cnt = 0;
    end else if (bus.Busy) begin
      busy_cnt++;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge Clock);
    bus.Start = 1'b1; bus.Op = op; bus.OpA = a; bus.OpB = b;
    e = model(op, a, b);
    e.issue = cyc;
    sb_q.push_back(e);
    @(negedge Clock);
    bus.Start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.Done && n < 200) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 200) chk("done_timeout", 64'd0, 64'd1);
    @(negedge Clock);
  endtask

  task automatic wait_count(input int target);
    int n = 0;
    while (bus.Count != CW'(target) && n < 200) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 200) chk("count_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int hold_count;
    Reset = 1'b0;
    bus.Start = 1'b0; bus.Op = 2'd0; bus.OpA = '0; bus.OpB = '0;
    bus.LoadHi = 1'b0; bus.LoadLo = 1'b0; bus.WrData = '0;
    repeat (3) @(negedge Clock);
    chk("rst_hi", bus.Hi, 0);
    chk("rst_lo", bus.Lo, 0);
    chk("rst_count", bus.Count, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_divzero", bus.DivZero, 0);
    Reset = 1'b1;
    @(negedge Clock);

    issue(2'd0, 32'hFFFF_FFFD, 32'd7);          wait_done();
    chk("mult_neg_hi", bus.Hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", bus.Lo, 32'hFFFF_FFEB);
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  wait_done();
    chk("multu_max_hi", bus.Hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", bus.Lo, 32'h0000_0001);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2);          wait_done();
    chk("div_neg_lo", bus.Lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", bus.Hi, 32'hFFFF_FFFF);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);  wait_done();
    chk("div_ovf_lo", bus.Lo, 32'h8000_0000);
    chk("div_ovf_hi", bus.Hi, 32'h0);
    issue(2'd3, 32'd100, 32'd0);                wait_done();
    chk("divzero_hi", bus.Hi, 32'd100);
    chk("divzero_lo", bus.Lo, 32'hFFFF_FFFF);

    // Start and LoadHi while busy are both dropped
`ifdef MULDIV_EARLY_OUT_EN
    hold_count = 2;
`else
    hold_count = 10;
`endif
    issue(2'd1, 32'd5, 32'd6);
    wait_count(hold_count);
    bus.Start = 1'b1; bus.Op = 2'd3; bus.OpA = 32'd77; bus.OpB = 32'd9;
    bus.LoadHi = 1'b1; bus.WrData = 32'h0000_AAAA;
    @(negedge Clock);
    bus.Start = 1'b0; bus.LoadHi = 1'b0;
    wait_done();
    chk("busy_ign_hi", bus.Hi, 32'd0);
    chk("busy_ign_lo", bus.Lo, 32'd30);
    bus.LoadLo = 1'b1; bus.WrData = 32'h0000_1234;
    @(negedge Clock);
    bus.LoadLo = 1'b0;
    chk("mtlo_lo", bus.Lo, 32'h0000_1234);
    chk("mtlo_hi", bus.Hi, 32'd0);
    bus.LoadHi = 1'b1; bus.LoadLo = 1'b1; bus.WrData = 32'h5A5A_0F0F;
    @(negedge Clock);
    bus.LoadHi = 1'b0; bus.LoadLo = 1'b0;
    chk("mthilo_hi", bus.Hi, 32'h5A5A_0F0F);
    chk("mthilo_lo", bus.Lo, 32'h5A5A_0F0F);

    // Same-edge Start and LoadHi: load lands first, result overwrites at completion
    @(negedge Clock);
    bus.Start = 1'b1; bus.Op = 2'd3; bus.OpA = 32'd1000; bus.OpB = 32'd7;
    bus.LoadHi = 1'b1; bus.WrData = 32'hDEAD_BEEF;
    begin
      exp_t e;
      e = model(2'd3, 32'd1000, 32'd7);
      e.issue = cyc;
      sb_q.push_back(e);
    end
    @(negedge Clock);
    bus.Start = 1'b0; bus.LoadHi = 1'b0;
    chk("start_load_hi", bus.Hi, 32'hDEAD_BEEF);
    wait_done();

    // Reset mid-divide aborts without touching Hi/Lo beyond clearing them
    issue(2'd2, 32'd1000, 32'd3);
    wait_count(12);
    Reset = 1'b0;
    sb_q.delete();
    #1;
    chk("abort_hi", bus.Hi, 0);
    chk("abort_lo", bus.Lo, 0);
    chk("abort_busy", bus.Busy, 0);
    chk("abort_count", bus.Count, 0);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    issue(2'd3, 32'd1000, 32'd3);               wait_done();
    chk("divu_lo", bus.Lo, 32'd333);
    chk("divu_hi", bus.Hi, 32'd1);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      issue(op, a, b);
      wait_done();
    end

    repeat (3) @(negedge Clock);
    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_unit.md
Name:
muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Successor to the fixed 32-bit shift-add multiplier and its free-running HighMult/LowMult registers.
- Adds width parameter, signed/unsigned multiply and divide, a Start/Busy/Done handshake, divide-by-zero flag and direct HI/LO writes for MTHI/MTLO.
- Sits beside the ALU in the multicycle datapath: the controller pulses Start and waits for Done; MFHI/MFLO read Hi/Lo through the register-write mux.

Parameters:
- WIDTH, 32, operand width; Hi and Lo are WIDTH bits each; must be >= 4.
- CNT_W, $clog2(WIDTH)+1, width of the Count output.

Ports:
- Clock  in  1  single clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  begin operation; sampled only in IDLE.
- Op  in  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
- OpA  in  WIDTH  multiplicand / dividend; sampled with Start.
- OpB  in  WIDTH  multiplier / divisor; sampled with Start.
- LoadHi  in  1  write WrData into Hi (MTHI).
- LoadLo  in  1  write WrData into Lo (MTLO).
- WrData  in  WIDTH  data for LoadHi/LoadLo.
- Busy  out  1  high in CALC and FIX.
- Done  out  1  one-cycle completion pulse (high in state DONE).
- DivZero  out  1  high together with Done when a DIV/DIVU had OpB==0.
- Hi  out  WIDTH  HI register: multiply upper half, or divide remainder.
- Lo  out  WIDTH  LO register: multiply lower half, or divide quotient.
- Count  out  CNT_W  iterations completed in the current operation.

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE; Hi=Lo=0, Count=0, Busy=Done=DivZero=0; all internal operand and accumulator registers cleared. Reset mid-operation aborts the operation; no partial result reaches Hi/Lo.
- States: IDLE, CALC, FIX, DONE. All outputs are registered or decoded from state only (Moore).
- IDLE with Start=1 (edge 0):
  - Latch Op and the sign flags.
  - Signed ops latch |OpA| and |OpB|; unsigned ops latch the raw values.
  - Count=0; go to CALC.
  - Exception: DIV/DIVU with OpB==0 goes straight to DONE and writes Hi=OpA, Lo=all ones, DivZero=1.
- CALC:
  - One iteration per edge; Count increments each edge.
  - Multiply: radix-2 shift-add on a 2*WIDTH-bit product.
  - Divide: restoring shift-subtract of the magnitudes.
  - Go to FIX on the edge where Count reaches WIDTH.
- FIX (one edge):
  - Multiply: negate the product if the operand signs differ (signed only); Hi=product[2W-1:W], Lo=product[W-1:0].
  - Divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Go to DONE.
- DONE: Done=1 for exactly one cycle, then IDLE. DivZero clears when leaving DONE.
- Latency: Done is high in the cycle after edge WIDTH+1, counted from the Start-sampling edge (33 edges for WIDTH=32). Divide-by-zero: Done in the cycle after edge 0.
- Signed overflow (MIN / -1): Lo=MIN, Hi=0; this falls out of magnitude arithmetic truncated to WIDTH bits. No flag.
- Start while Busy or in DONE: ignored; no queuing.
- LoadHi/LoadLo:
  - Honoured in IDLE and DONE; ignored in CALC and FIX.
  - Same-edge Start and LoadHi in IDLE: the load takes effect, and the completed result later overwrites it.
  - LoadHi and LoadLo together write both registers.
- Hi/Lo hold their value except on reset, a FIX completion, a divide-by-zero completion, or LoadHi/LoadLo.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined, multiply only: CALC exits to FIX as soon as the remaining unshifted multiplier bits are all zero.
  - The product is pre-aligned so the result is identical to the full run.
  - Count shows the iterations actually performed.
  - Latency is variable: minimum 3 edges for OpB==0 (edge 0, one CALC edge, FIX).
  - Divide timing is unchanged.
- Undefined: fixed WIDTH iterations for every operation, as specified above.

Test Plan:
- MULT OpA=0xFFFFFFFD (-3), OpB=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Done high exactly after edge 33; Busy high for edges 1..33.
- MULTU OpA=OpB=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001, DivZero=0.
- DIV OpA=0xFFFFFFF9 (-7), OpB=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1). Then DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU OpA=100, OpB=0 -> Done and DivZero in the cycle after edge 0; Hi=100, Lo=0xFFFFFFFF; Busy never asserted.
- MULTU 5*6 started, Start with new operands plus LoadHi=0xAAAA pulsed at Count=10 -> both ignored; result Hi=0, Lo=30. After Done, LoadLo WrData=0x1234 -> Lo=0x1234, Hi unchanged.
- Reset asserted at Count=12 of DIV 1000/3 -> immediately IDLE, Hi=Lo=0, Busy=0. After release, a fresh DIVU 1000/3 -> Lo=333, Hi=1.
